// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
// Purpose: FSM state encoding, default operand width and counter sizing.
// Ports: none (package).
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;

  // Counter must hold the value ITERS itself, hence ITERS+1 codes.
  function automatic int cnt_width(input int iters);
    return $clog2(iters + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/zero_detect32.sv
// rtl/zero_detect32.sv - combinational all-zero detector for the divisor
// Purpose: flags a zero operand with a WIDTH-input NOR reduction.
// Ports:
//   value - operand under test (WIDTH bits)
//   zero  - 1 when every bit of value is 0
module zero_detect32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  assign zero = ~|value;

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - signed restoring divider, one quotient bit per cycle
// Purpose: divides data_operandA by data_operandB (signed, truncating toward
//   zero) using ITERS shift-subtract steps on operand magnitudes, then applies
//   the quotient sign in a fixup cycle.
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous active-high reset
//   ctrl_DIV       - start pulse; operands sampled on the same edge
//   data_operandA  - signed dividend
//   data_operandB  - signed divisor
//   data_result    - signed quotient, held until the next start
//   data_exception - divide-by-zero flag for data_result
//   data_resultRDY - one-cycle completion pulse (DONE state)
//   busy           - high while RUN or FIXUP
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = cnt_width(ITERS);
  localparam logic [CW-1:0] LAST_STEP = CW'(ITERS - 1);

  div_state_e       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;       // starts as |A|, shifts out dividend bits, shifts in quotient bits
  logic [WIDTH-1:0] divisor;
  logic             neg_q;

  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             diff_neg;
  logic [WIDTH:0]   rem_next;

  zero_detect32 #(.WIDTH(WIDTH)) u_zero_detect (
    .value (data_operandB),
    .zero  (b_zero)
  );

  // Magnitudes as unsigned WIDTH-bit values; -2^(WIDTH-1) maps to 2^(WIDTH-1).
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // Restoring step: the remainder stays below the divisor, so the shifted
  // value fits WIDTH+1 bits and the top bit of diff is a clean borrow.
  always_comb begin
    shifted  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff     = {rem, quo[WIDTH-1]} - {2'b00, divisor};
    diff_neg = diff[WIDTH+1];
    rem_next = diff_neg ? shifted : diff[WIDTH:0];
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state == RUN) || (state == FIXUP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      neg_q          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      // A start in any state (re)launches the divide with the new operands.
      cnt            <= '0;
      rem            <= '0;
      quo            <= a_mag;
      divisor        <= b_mag;
      neg_q          <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      data_result    <= '0;
      data_exception <= b_zero;
      state          <= b_zero ? DONE : RUN;
    end else begin
      unique case (state)
        IDLE: ;
        RUN: begin
          rem <= rem_next;
          quo <= {quo[WIDTH-2:0], ~diff_neg};
          cnt <= cnt + CW'(1);
          if (cnt == LAST_STEP) state <= FIXUP;
        end
        FIXUP: begin
          data_result    <= neg_q ? -quo : quo;
          data_exception <= 1'b0;
          state          <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
